// File: rtl/game_round_ctrl.sv
// game_round_ctrl: deals four LFSR cards, pulses START, times the round and tracks score/streak.
// Optional countdown timer is built when GAME_TIMER_EN is defined.
module game_round_ctrl #(
   parameter int          MAX_CARD    = 10,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter int          TICK_DIV    = 100000000,
   parameter int          ROUND_SECS  = 60,
   parameter int          RESULT_HOLD = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       new_game,
   input  logic       win,
   input  logic       lose,
   output logic [9:0] m1,
   output logic [9:0] m2,
   output logic [9:0] m3,
   output logic [9:0] m4,
   output logic       start_o,
   output logic [6:0] time_left,
   output logic [7:0] score,
   output logic [7:0] streak,
   output logic       timeout,
   output logic [1:0] phase
);
   typedef enum logic [1:0] {IDLE = 2'b00, DEAL = 2'b01, PLAY = 2'b10, RESULT = 2'b11} state_t;
   state_t      state_q;
   logic [15:0] lfsr_q, lfsr_d;
   logic [3:0]  m_q [4];
   logic [1:0]  k_q;
   logic [1:0]  guard_q;
   logic        start_q;
   logic [7:0]  score_q, streak_q, score_inc, streak_inc;
   logic [3:0]  card;
   logic        card_ok, guarded, lose_ok, win_ok, expire;
   assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign card       = lfsr_q[3:0];
   assign card_ok    = card != 4'd0 && card <= 4'(MAX_CARD);
   assign guarded    = guard_q != 2'd0;
   assign lose_ok    = lose && !guarded;
   assign win_ok     = win && !lose && !guarded;
   assign score_inc  = score_q == 8'hFF ? score_q : score_q + 8'd1;
   assign streak_inc = streak_q == 8'hFF ? streak_q : streak_q + 8'd1;
`ifdef GAME_TIMER_EN
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [PW-1:0] presc_q;
   logic [7:0]    hold_q;
   logic [6:0]    time_q;
   logic          timeout_q;
   logic          tick;
   assign tick      = presc_q == PW'(TICK_DIV - 1);
   assign expire    = tick && time_q == 7'd1;
   assign time_left = time_q;
   assign timeout   = timeout_q;
`else
   logic unused_cfg;
   assign unused_cfg = (TICK_DIV + ROUND_SECS + RESULT_HOLD) > 0;
   assign expire     = 1'b0;
   assign time_left  = 7'd0;
   assign timeout    = 1'b0;
`endif
   assign m1      = {6'd0, m_q[0]};
   assign m2      = {6'd0, m_q[1]};
   assign m3      = {6'd0, m_q[2]};
   assign m4      = {6'd0, m_q[3]};
   assign start_o = start_q;
   assign score   = score_q;
   assign streak  = streak_q;
   assign phase   = state_q;
   // Round sequencer: deal, play with guard and countdown, result hold, scoring.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         lfsr_q   <= LFSR_SEED;
         m_q      <= '{default: 4'd0};
         k_q      <= 2'd0;
         guard_q  <= 2'd0;
         start_q  <= 1'b0;
         score_q  <= 8'd0;
         streak_q <= 8'd0;
`ifdef GAME_TIMER_EN
         presc_q   <= '0;
         hold_q    <= 8'd0;
         time_q    <= 7'd0;
         timeout_q <= 1'b0;
`endif
      end else begin
         lfsr_q  <= lfsr_d;
         start_q <= 1'b0;
`ifdef GAME_TIMER_EN
         presc_q <= tick ? '0 : presc_q + PW'(1);
`endif
         case (state_q)
            IDLE: begin
               if (new_game) begin
                  state_q <= DEAL;
                  k_q     <= 2'd0;
               end
            end
            DEAL: begin
               if (card_ok) begin
                  m_q[k_q] <= card;
                  k_q      <= k_q + 2'd1;
                  if (k_q == 2'd3) begin
                     state_q <= PLAY;
                     start_q <= 1'b1;
                     guard_q <= 2'd3;
`ifdef GAME_TIMER_EN
                     time_q  <= 7'(ROUND_SECS);
                     presc_q <= '0;
`endif
                  end
               end
            end
            PLAY: begin
               if (guarded) guard_q <= guard_q - 2'd1;
               if (new_game) begin
                  state_q  <= DEAL;
                  k_q      <= 2'd0;
                  streak_q <= 8'd0;
               end else if (lose_ok || win_ok || expire) begin
                  state_q  <= RESULT;
                  score_q  <= win_ok ? score_inc : score_q;
                  streak_q <= win_ok ? streak_inc : 8'd0;
`ifdef GAME_TIMER_EN
                  timeout_q <= !win_ok && !lose_ok;
                  time_q    <= win_ok || lose_ok ? time_q : 7'd0;
                  presc_q   <= '0;
                  hold_q    <= 8'd0;
               end else if (tick) begin
                  time_q <= time_q - 7'd1;
`endif
               end
            end
            RESULT: begin
               if (new_game) begin
                  state_q <= DEAL;
                  k_q     <= 2'd0;
`ifdef GAME_TIMER_EN
                  timeout_q <= 1'b0;
               end else if (tick && hold_q == 8'(RESULT_HOLD - 1)) begin
                  state_q   <= IDLE;
                  timeout_q <= 1'b0;
               end else if (tick) begin
                  hold_q <= hold_q + 8'd1;
               end
`else
               end else begin
                  state_q <= IDLE;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
